// File: rtl/fib_seq_gen.sv
// Second-order recurrence engine T(k) = c*T(k-1) + T(k-2), c in {1,2}, with sticky overflow.
// Latency n+1 cycles from the accepting edge; result is held in DONE until i_ready.
// Define FIB_SEQ_GEN_SAT_EN for saturating arithmetic; the default build wraps modulo 2^WIDTH.
module fib_seq_gen #(
    parameter int WIDTH   = 32,
    parameter int N_WIDTH = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_stb,
    input  logic [N_WIDTH-1:0] i_n,
    input  logic [WIDTH-1:0]   i_seed0,
    input  logic [WIDTH-1:0]   i_seed1,
    input  logic               i_mode,
    output logic               o_busy,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WIDTH-1:0]   o_fib,
    output logic               o_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   cur;
    logic [WIDTH-1:0]   nxt;
    logic [N_WIDTH-1:0] cnt;
    logic               mode_q;
    logic               nxt_ovf;

    logic [WIDTH+1:0]   sum;
    logic               carry;
    logic [WIDTH-1:0]   nxt_f;

    // Two guard bits cover the worst case 2*(2^W-1) + (2^W-1).
    always_comb begin
        sum   = ({2'b00, nxt} << mode_q) + {2'b00, cur};
        carry = |sum[WIDTH+1:WIDTH];
`ifdef FIB_SEQ_GEN_SAT_EN
        nxt_f = (carry || nxt_ovf) ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
`else
        nxt_f = sum[WIDTH-1:0];
`endif
    end

    assign o_fib = cur;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= IDLE;
            o_busy  <= 1'b0;
            o_valid <= 1'b0;
            o_ovf   <= 1'b0;
            cur     <= '0;
            nxt     <= {{(WIDTH-1){1'b0}}, 1'b1};
            cnt     <= '0;
            mode_q  <= 1'b0;
            nxt_ovf <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_stb) begin
                        state   <= RUN;
                        o_busy  <= 1'b1;
                        cur     <= i_seed0;
                        nxt     <= i_seed1;
                        cnt     <= i_n;
                        mode_q  <= i_mode;
                        nxt_ovf <= 1'b0;
                        o_ovf   <= 1'b0;
                    end
                end
                RUN: begin
                    // o_ovf only picks up overflow once the bad value lands in cur.
                    if (cnt != '0) begin
                        cur     <= nxt;
                        nxt     <= nxt_f;
                        cnt     <= cnt - 1'b1;
                        o_ovf   <= o_ovf | nxt_ovf;
                        nxt_ovf <= nxt_ovf | carry;
                    end else begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                        o_busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_valid <= 1'b0;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_seq_gen.sv
// Bench for fib_seq_gen: 32-bit and 8-bit instances share stimulus and are checked against an exact-arithmetic model.
module tb_fib_seq_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [15:0] n_in = '0;
    logic [31:0] seed0 = '0;
    logic [31:0] seed1 = '0;
    logic        mode = 1'b0;
    logic        ready = 1'b1;

    logic        busy32, valid32, ovf32;
    logic [31:0] fib32;
    logic        busy8, valid8, ovf8;
    logic [7:0]  fib8;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    fib_seq_gen #(.WIDTH(32), .N_WIDTH(16)) dut32 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_n(n_in),
        .i_seed0(seed0), .i_seed1(seed1), .i_mode(mode),
        .o_busy(busy32), .o_valid(valid32), .i_ready(ready),
        .o_fib(fib32), .o_ovf(ovf32)
    );

    fib_seq_gen #(.WIDTH(8), .N_WIDTH(16)) dut8 (
        .i_clk(clk), .i_reset(rst), .i_stb(stb), .i_n(n_in),
        .i_seed0(seed0[7:0]), .i_seed1(seed1[7:0]), .i_mode(mode),
        .o_busy(busy8), .o_valid(valid8), .i_ready(ready),
        .o_fib(fib8), .o_ovf(ovf8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Exact recurrence in 64-bit integers, then reduced to the target width.
    function automatic void model(input int w, input int n, input longint s0, input longint s1,
                                  input bit m, output longint val, output bit ovf);
        longint a, b, t, lim;
        a = s0;
        b = s1;
        lim = longint'(1) << w;
        ovf = 1'b0;
        for (int k = 0; k < n; k++) begin
            t = (m ? 2 : 1) * b + a;
            a = b;
            b = t;
            if (a >= lim) ovf = 1'b1;
        end
`ifdef FIB_SEQ_GEN_SAT_EN
        val = ovf ? lim - 1 : a;
`else
        val = a % lim;
`endif
    endfunction

    // Transaction-level model: idle / computing (countdown) / holding a result.
    bit     m_busy, m_valid, m_ovf32, m_ovf8, p_ovf32, p_ovf8;
    longint m_fib32, m_fib8, p_fib32, p_fib8;
    int     m_wait;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_fib32 = 0; m_fib8 = 0; m_ovf32 = 0; m_ovf8 = 0; m_wait = 0;
        end else if (!m_busy) begin
            if (stb) begin
                m_busy = 1;
                m_wait = int'(n_in) + 1;
                model(32, int'(n_in), longint'(seed0), longint'(seed1), mode, p_fib32, p_ovf32);
                model(8, int'(n_in), longint'(seed0[7:0]), longint'(seed1[7:0]), mode, p_fib8, p_ovf8);
            end
        end else if (!m_valid) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1;
                m_fib32 = p_fib32; m_ovf32 = p_ovf32;
                m_fib8 = p_fib8;   m_ovf8 = p_ovf8;
            end
        end else if (ready) begin
            m_valid = 0;
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy32", busy32, m_busy);
            check("valid32", valid32, m_valid);
            check("busy8", busy8, m_busy);
            check("valid8", valid8, m_valid);
            if (!m_busy || m_valid) begin
                check("fib32", fib32, m_fib32);
                check("ovf32", ovf32, m_ovf32);
                check("fib8", fib8, m_fib8);
                check("ovf8", ovf8, m_ovf8);
            end
        end
    end

    task automatic start(input int n, input int s0, input int s1, input bit m);
        @(negedge clk);
        n_in = 16'(n); seed0 = 32'(s0); seed1 = 32'(s1); mode = m; stb = 1'b1;
        @(posedge clk);
        #1 stb = 1'b0;
    endtask

    // Call #1 after the accepting edge; returns edges until o_valid.
    task automatic wait_valid(input string name, input int n);
        int cyc;
        cyc = 0;
        while (!valid32 && cyc < 200) begin
            @(posedge clk);
            #1 cyc++;
        end
        check({name, "_latency"}, cyc, n + 1);
    endtask

    task automatic release_result();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", busy32, 0);
        check("reset_valid", valid32, 0);
        check("reset_fib", fib32, 0);
        check("reset_ovf", ovf32, 0);
        rst = 1'b0;
        chk_en = 1'b1;

        start(10, 0, 1, 0);
        wait_valid("fib10", 10);
        check("fib10_val", fib32, 55);
        check("fib10_ovf", ovf32, 0);
        release_result();

        start(5, 2, 1, 0);
        wait_valid("lucas5", 5);
        check("lucas5_val", fib32, 11);
        release_result();

        start(5, 0, 1, 1);
        wait_valid("pell5", 5);
        check("pell5_val", fib32, 29);
        release_result();

        start(0, 7, 9, 0);
        wait_valid("n0", 0);
        check("n0_val", fib32, 7);
        release_result();

        start(13, 0, 1, 0);
        wait_valid("w8_n13", 13);
        check("w8_n13_val", fib8, 233);
        check("w8_n13_ovf", ovf8, 0);
        release_result();

        start(14, 0, 1, 0);
        wait_valid("w8_n14", 14);
`ifdef FIB_SEQ_GEN_SAT_EN
        check("w8_n14_val", fib8, 255);
`else
        check("w8_n14_val", fib8, 121);
`endif
        check("w8_n14_ovf", ovf8, 1);
        check("w32_n14_val", fib32, 377);
        check("w32_n14_ovf", ovf32, 0);
        release_result();

        // Backpressure: result held, start pulses ignored while busy.
        ready = 1'b0;
        start(10, 0, 1, 0);
        wait_valid("bp", 10);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_in = 16'd3; stb = 1'b1;
            @(posedge clk);
            #1 stb = 1'b0;
            check("bp_hold_valid", valid32, 1);
            check("bp_hold_fib", fib32, 55);
        end
        @(negedge clk);
        ready = 1'b1; stb = 1'b1; n_in = 16'd3;
        @(posedge clk);
        #1 stb = 1'b0;
        check("bp_release_busy", busy32, 0);
        check("bp_release_valid", valid32, 0);
        start(3, 0, 1, 0);
        wait_valid("bp_next", 3);
        check("bp_next_val", fib32, 2);
        release_result();

        // Reset during the fourth RUN cycle discards the job.
        start(10, 0, 1, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_busy", busy32, 0);
        check("rst_valid", valid32, 0);
        check("rst_fib", fib32, 0);
        check("rst_ovf", ovf32, 0);
        start(6, 0, 1, 0);
        wait_valid("post_rst", 6);
        check("post_rst_val", fib32, 8);
        release_result();

        repeat (3) @(posedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fib_seq_gen.md
Name: fib_seq_gen

Overview:
- Parametrised successor to the single-mode Fibonacci engine.
- Computes the nth term of a second-order recurrence T(k) = c*T(k-1) + T(k-2), with programmable seeds T(0), T(1) and a selectable coefficient c (Fibonacci/Lucas-style c=1, Pell-style c=2).
- Provides a start strobe, a valid/ready result handshake and a sticky overflow flag.
- Sits behind a register/host interface as a multi-cycle arithmetic peripheral.

Parameters:
- WIDTH, 32: data width of seeds and result.
- N_WIDTH, 16: width of the term index i_n.

Ports:
- i_clk  input  1  clock, rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_stb  input  1  start request; accepted only in IDLE.
- i_n  input  N_WIDTH  term index to compute.
- i_seed0  input  WIDTH  T(0).
- i_seed1  input  WIDTH  T(1).
- i_mode  input  1  0: c=1; 1: c=2 (Pell).
- o_busy  output  1  high in RUN and DONE.
- o_valid  output  1  result valid, high in DONE.
- i_ready  input  1  consumer accepts result.
- o_fib  output  WIDTH  result T(n).
- o_ovf  output  1  overflow occurred for this result.

Behaviour:
- One clock domain: i_clk. Reset is synchronous and active-high on i_reset, with priority over all other logic.
- Reset values: state=IDLE, o_busy=0, o_valid=0, o_fib=0, o_ovf=0, internal count=0, nxt=1, nxt overflow bit=0.
- Internal registers:
  - cur (drives o_fib) and nxt, both WIDTH bits.
  - cnt, N_WIDTH bits.
  - mode_q.
  - nxt_ovf: 1 bit, marks nxt as out of range.
- FSM state IDLE:
  - On i_stb: latch cur<=i_seed0, nxt<=i_seed1, cnt<=i_n, mode_q<=i_mode, nxt_ovf<=0, o_ovf<=0; go to RUN.
  - Otherwise outputs hold their last values.
- FSM state RUN, per cycle:
  - If cnt!=0: cur<=nxt, nxt<=f(c*nxt+cur), cnt<=cnt-1, o_ovf<=o_ovf|nxt_ovf, nxt_ovf<=nxt_ovf|carry.
  - If cnt==0: go to DONE.
- FSM state DONE:
  - o_valid=1. o_fib and o_ovf are held stable.
  - When i_ready=1 at an edge, go to IDLE and drop o_valid next cycle.
- Latency: o_valid rises n+1 cycles after the accepting edge. n=0 gives 1 cycle, output = seed0.
- Arithmetic:
  - The sum is computed WIDTH+2 bits wide. carry = any bit above WIDTH-1 set.
  - f() wraps modulo 2^WIDTH (see Optional Feature).
  - c=2 is implemented as a left shift by 1.
- Overflow semantics:
  - o_ovf reflects only values that reached cur.
  - An overflowed nxt (T(n+1)) left uncomputed into cur does not set o_ovf.
- Handshake:
  - i_stb is ignored while o_busy=1.
  - i_stb in the same cycle as the DONE->IDLE transition is ignored; it is accepted from IDLE only.
  - i_n, seeds and mode are sampled only at the accepting edge; later changes have no effect.
- Reset mid-RUN or mid-DONE: returns to IDLE with reset values next cycle; the pending result is discarded.

Optional Feature:
- Macro FIB_SEQ_GEN_SAT_EN.
- Defined: f() saturates, so any carry yields all-ones. Once nxt or cur is all-ones it remains all-ones; o_ovf behaves as above.
- Undefined: f() wraps modulo 2^WIDTH. o_ovf is still reported.

Test Plan:
- Fibonacci: WIDTH=32, seeds 0,1, mode 0, n=10 -> o_valid after 11 cycles, o_fib=55, o_ovf=0.
- Lucas and Pell:
  - Seeds 2,1, mode 0, n=5 -> o_fib=11.
  - Seeds 0,1, mode 1, n=5 -> o_fib=29.
  - n=0, seeds 7,9 -> o_fib=7 after 1 cycle.
- Overflow, WIDTH=8, seeds 0,1, mode 0:
  - n=13 -> 233, o_ovf=0.
  - n=14 -> 121 and o_ovf=1 (wrap build); 255 and o_ovf=1 (FIB_SEQ_GEN_SAT_EN build).
- Backpressure: result 55 with i_ready low 5 cycles -> o_valid stays 1, o_fib stays 55; i_stb pulses with n=3 are ignored. Raise i_ready -> IDLE; next i_stb n=3 -> o_fib=2.
- Reset: assert i_reset in the 4th RUN cycle of n=10 -> next cycle o_busy=0, o_valid=0, o_fib=0, o_ovf=0. A new start n=6 -> o_fib=8.
